lamp_fpu_sqrt_issue: RTL

//  Upstream issue/retire controller for the bfloat16 square-root unit (lampFPU_sqrt).
//  - Accepts one raw 16-bit operand per valid/ready handshake.
//  - Unpacks and classifies the operand, then drives the sqrt operand/flag inputs with a 1-cycle doSqrt pulse.
//  - Waits for the sqrt valid, repacks {s,e,f} into a 16-bit result and holds it under a valid/ready handshake.
//  - Guards against a missing completion with a timeout counter.

---
 rtl/lamp_fpu_sqrt_issue.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lamp_fpu_sqrt_issue.sv
// Issue/retire controller for the bfloat16 square-root unit.
// Accepts one raw operand, unpacks and classifies it, fires a single-cycle
// start pulse at the sqrt unit, then waits for its completion (or a timeout)
// and presents the repacked result under a valid/ready handshake.
module lamp_fpu_sqrt_issue #(
    parameter int E_DW    = 8,
    parameter int F_DW    = 7,
    parameter int TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid_i,
    output logic                op_ready_o,
    input  logic [E_DW+F_DW:0]  op_i,
    output logic                doSqrt_o,
    output logic                signum_op_o,
    output logic [E_DW-1:0]     extExp_op_o,
    output logic [F_DW:0]       extMant_op_o,
    output logic                isInf_op_o,
    output logic                isZero_op_o,
    output logic                isSNAN_op_o,
    output logic                isQNAN_op_o,
    input  logic                sqrt_s_i,
    input  logic [E_DW-1:0]     sqrt_e_i,
    input  logic [F_DW-1:0]     sqrt_f_i,
    input  logic                sqrt_valid_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [E_DW+F_DW:0]  res_o,
    output logic                timeout_o
);

    localparam int W    = 1 + E_DW + F_DW;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    // Canonical quiet NaN: positive, all-ones exponent, top fraction bit set.
    localparam logic [W-1:0] QNAN = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [TO_W-1:0] timer_reg;
    logic            signum_reg;
    logic [E_DW-1:0] ext_exp_reg;
    logic [F_DW:0]   ext_mant_reg;
    logic            is_inf_reg;
    logic            is_zero_reg;
    logic            is_snan_reg;
    logic            is_qnan_reg;
    logic [W-1:0]    res_reg;
    logic            timeout_reg;

    // Raw operand fields and exponent/fraction classification terms.
    logic            op_s;
    logic [E_DW-1:0] op_e;
    logic [F_DW-1:0] op_f;
    logic            e_zero;
    logic            e_max;
    logic            f_zero;

    assign op_s   = op_i[W-1];
    assign op_e   = op_i[W-2:F_DW];
    assign op_f   = op_i[F_DW-1:0];
    assign e_zero = (op_e == '0);
    assign e_max  = &op_e;
    assign f_zero = (op_f == '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and handshake/strobe outputs.
    always_comb begin
        state_next  = state_reg;
        op_ready_o  = 1'b0;
        doSqrt_o    = 1'b0;
        res_valid_o = 1'b0;
        case (state_reg)
            IDLE: begin
                // Held low while reset is asserted so every output reads 0.
                op_ready_o = rst;
                if (op_valid_i) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                doSqrt_o   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A completion on the last timer cycle still counts as real.
                if (sqrt_valid_i || (timer_reg == TO_LAST)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, wait timer and result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_reg    <= '0;
            signum_reg   <= 1'b0;
            ext_exp_reg  <= '0;
            ext_mant_reg <= '0;
            is_inf_reg   <= 1'b0;
            is_zero_reg  <= 1'b0;
            is_snan_reg  <= 1'b0;
            is_qnan_reg  <= 1'b0;
            res_reg      <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (op_valid_i) begin
                        signum_reg   <= op_s;
                        ext_exp_reg  <= op_e;
                        // Denormals are flushed to zero; the sign survives.
                        ext_mant_reg <= e_zero ? '0 : {1'b1, op_f};
                        is_zero_reg  <= e_zero;
                        is_inf_reg   <= e_max & f_zero;
                        is_qnan_reg  <= e_max & op_f[F_DW-1];
                        is_snan_reg  <= e_max & ~f_zero & ~op_f[F_DW-1];
                    end
                end
                ISSUE: begin
                    timer_reg <= '0;
                end
                WAIT: begin
                    timer_reg <= timer_reg + TO_W'(1);
                    if (sqrt_valid_i) begin
                        res_reg     <= {sqrt_s_i, sqrt_e_i, sqrt_f_i};
                        timeout_reg <= 1'b0;
                    end else if (timer_reg == TO_LAST) begin
                        res_reg     <= QNAN;
                        timeout_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        timeout_reg <= 1'b0;
                    end
                end
                default: begin
                    timer_reg <= '0;
                end
            endcase
        end
    end

    assign signum_op_o  = signum_reg;
    assign extExp_op_o  = ext_exp_reg;
    assign extMant_op_o = ext_mant_reg;
    assign isInf_op_o   = is_inf_reg;
    assign isZero_op_o  = is_zero_reg;
    assign isSNAN_op_o  = is_snan_reg;
    assign isQNAN_op_o  = is_qnan_reg;
    assign res_o        = res_reg;
    assign timeout_o    = timeout_reg;

endmodule
